// File: rtl/gp_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gp_read_arbiter
// Description : Two-requester DRAM read arbiter. Grants are combinational,
//               round-robin between requester 0 (command fetch) and
//               requester 1 (fill/line engine), and are written straight into
//               the DRAM address FIFO. A tag FIFO remembers the issue order
//               so that returning read-data beats are routed back to the
//               requester that issued them, BEATS beats per request.
//
// Ports       : clk, rst             - clock, synchronous active-high reset
//               r0_req/addr/gnt      - requester 0 request, address, grant
//               r0_rd_valid          - read beat valid for requester 0
//               r1_req/addr/gnt      - requester 1 request, address, grant
//               r1_rd_valid          - read beat valid for requester 1
//               rd_data              - shared read data (rdf_dout passthrough)
//               af_full/wr_en/addr_din - DRAM address FIFO interface
//               rdf_valid/dout/rd_en - DRAM read-data FIFO interface
//               busy                 - one or more requests outstanding
//               err_orphan           - sticky: beat seen with nothing
//                                      outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module gp_read_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int BEATS   = 2
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         r0_req,
    input  logic [30:0]  r0_addr,
    output logic         r0_gnt,
    output logic         r0_rd_valid,

    input  logic         r1_req,
    input  logic [30:0]  r1_addr,
    output logic         r1_gnt,
    output logic         r1_rd_valid,

    output logic [127:0] rd_data,

    input  logic         af_full,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,

    input  logic         rdf_valid,
    input  logic [127:0] rdf_dout,
    output logic         rdf_rd_en,

    output logic         busy,
    output logic         err_orphan
);

    localparam int PW = $clog2(MAX_OUT);
    localparam int BW = $clog2(BEATS) + 1;

    localparam logic [PW:0]   c_max_out   = (PW+1)'(MAX_OUT);
    localparam logic [BW-1:0] c_last_beat = BW'(BEATS - 1);

    // Tag FIFO: one bit per outstanding request holding the requester ID.
    logic [MAX_OUT-1:0] r_tag_mem;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;
    logic [BW-1:0]      r_beat;
    // ID of the last granted requester. Reset to 1 so requester 0 wins
    // the first contended cycle.
    logic               r_last_gnt;
    logic               r_err_orphan;

    logic               w_can_issue;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_push;
    logic               w_pop_beat;
    logic               w_pop_tag;
    logic               w_head_tag;
    logic               w_outstanding;

    assign w_outstanding = (r_count != '0);
    assign w_can_issue   = !af_full && (r_count < c_max_out);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_can_issue) begin
            if (r0_req && r1_req) begin
                if (r_last_gnt) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (r0_req) begin
                w_gnt0 = 1'b1;
            end else if (r1_req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_push      = w_gnt0 | w_gnt1;
    assign r0_gnt      = w_gnt0;
    assign r1_gnt      = w_gnt1;
    assign af_wr_en    = w_push;
    assign af_addr_din = w_gnt0 ? r0_addr : (w_gnt1 ? r1_addr : 31'd0);

    // ------------------------------------------------------------------
    // Return path: beats are only popped against an outstanding tag, and
    // are routed to the requester at the head of the tag FIFO.
    // ------------------------------------------------------------------
    assign w_head_tag  = r_tag_mem[r_rd_ptr];
    assign w_pop_beat  = rdf_valid && w_outstanding;
    assign w_pop_tag   = w_pop_beat && (r_beat == c_last_beat);

    assign rdf_rd_en   = w_pop_beat;
    assign r0_rd_valid = w_pop_beat && !w_head_tag;
    assign r1_rd_valid = w_pop_beat &&  w_head_tag;
    assign rd_data     = rdf_dout;

    assign busy        = w_outstanding;
    assign err_orphan  = r_err_orphan;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_mem    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_beat       <= '0;
            r_last_gnt   <= 1'b1;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= w_gnt1;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
                r_last_gnt          <= w_gnt1;
            end

            if (w_pop_beat) begin
                r_beat <= w_pop_tag ? '0 : (r_beat + 1'b1);
            end

            if (w_pop_tag) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop_tag})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (rdf_valid && !w_outstanding) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gp_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_read_arbiter
// Description : Directed self-checking bench for gp_read_arbiter
//               (MAX_OUT=4, BEATS=2). Inputs change 1ns after each rising
//               edge; outputs are compared 3ns after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gp_read_arbiter;

    logic         clk;
    logic         rst;
    logic         r0_req;
    logic [30:0]  r0_addr;
    logic         r0_gnt;
    logic         r0_rd_valid;
    logic         r1_req;
    logic [30:0]  r1_addr;
    logic         r1_gnt;
    logic         r1_rd_valid;
    logic [127:0] rd_data;
    logic         af_full;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;
    logic         rdf_valid;
    logic [127:0] rdf_dout;
    logic         rdf_rd_en;
    logic         busy;
    logic         err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    gp_read_arbiter #(
        .MAX_OUT (4),
        .BEATS   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .r0_req      (r0_req),
        .r0_addr     (r0_addr),
        .r0_gnt      (r0_gnt),
        .r0_rd_valid (r0_rd_valid),
        .r1_req      (r1_req),
        .r1_addr     (r1_addr),
        .r1_gnt      (r1_gnt),
        .r1_rd_valid (r1_rd_valid),
        .rd_data     (rd_data),
        .af_full     (af_full),
        .af_wr_en    (af_wr_en),
        .af_addr_din (af_addr_din),
        .rdf_valid   (rdf_valid),
        .rdf_dout    (rdf_dout),
        .rdf_rd_en   (rdf_rd_en),
        .busy        (busy),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_req    = 1'b0;
        r0_addr   = '0;
        r1_req    = 1'b0;
        r1_addr   = '0;
        af_full   = 1'b0;
        rdf_valid = 1'b0;
        rdf_dout  = '0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        #2;
        n_checks++;
        if ({r0_gnt, r1_gnt, af_wr_en, rdf_rd_en, r0_rd_valid, r1_rd_valid, busy, err_orphan} !== 8'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {r0_gnt, r1_gnt, af_wr_en, rdf_rd_en, r0_rd_valid, r1_rd_valid, busy, err_orphan});
        end
        n_checks++;
        if (af_addr_din !== 31'd0) begin
            n_errors++;
            $display("FAIL reset_addr: got %h expected 0", af_addr_din);
        end
        step();
        rst = 1'b0;
        step();
        #2;
        n_checks++;
        if ({busy, err_orphan, af_wr_en} !== 3'b000) begin
            n_errors++;
            $display("FAIL post_reset_idle: got %b expected 000", {busy, err_orphan, af_wr_en});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        do_reset();
        step();
        r0_req  = 1'b1;
        r0_addr = 31'h0000123;
        #2;
        n_checks++;
        if ({r0_gnt, r1_gnt, af_wr_en} !== 3'b101) begin
            n_errors++;
            $display("FAIL single_gnt: got %b expected 101", {r0_gnt, r1_gnt, af_wr_en});
        end
        n_checks++;
        if (af_addr_din !== 31'h0000123) begin
            n_errors++;
            $display("FAIL single_addr: got %h expected 0000123", af_addr_din);
        end
        step();
        r0_req = 1'b0;
        #2;
        n_checks++;
        if ({busy, af_wr_en} !== 2'b10) begin
            n_errors++;
            $display("FAIL single_busy: got %b expected 10", {busy, af_wr_en});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            rdf_valid = 1'b1;
            rdf_dout  = {4{32'hC0DE_0000 + 32'(i)}};
            #2;
            n_checks++;
            if ({rdf_rd_en, r0_rd_valid, r1_rd_valid} !== 3'b110 || rd_data !== {4{32'hC0DE_0000 + 32'(i)}}) begin
                n_errors++;
                $display("FAIL single_beat%0d: got en/v0/v1=%b data=%h expected 110 data=%h",
                         i, {rdf_rd_en, r0_rd_valid, r1_rd_valid}, rd_data, {4{32'hC0DE_0000 + 32'(i)}});
            end
        end
        step();
        rdf_valid = 1'b0;
        #2;
        n_checks++;
        if ({busy, err_orphan} !== 2'b00) begin
            n_errors++;
            $display("FAIL single_done: got busy/err=%b expected 00", {busy, err_orphan});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic exp0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            r0_req  = 1'b1;
            r1_req  = 1'b1;
            r0_addr = 31'h00000A0;
            r1_addr = 31'h00000B0;
            #2;
            exp0 = ((i % 2) == 0);
            n_checks++;
            if ({r0_gnt, r1_gnt, af_wr_en} !== {exp0, !exp0, 1'b1} ||
                af_addr_din !== (exp0 ? 31'h00000A0 : 31'h00000B0)) begin
                n_errors++;
                $display("FAIL rr_gnt%0d: got g0/g1/wr=%b addr=%h expected %b addr=%h", i,
                         {r0_gnt, r1_gnt, af_wr_en}, af_addr_din, {exp0, !exp0, 1'b1},
                         (exp0 ? 31'h00000A0 : 31'h00000B0));
            end
        end
        step();
        r0_req = 1'b0;
        r1_req = 1'b0;
        #2;
        n_checks++;
        if ({busy, af_wr_en} !== 2'b10) begin
            n_errors++;
            $display("FAIL rr_busy: got %b expected 10", {busy, af_wr_en});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            rdf_valid = 1'b1;
            rdf_dout  = 128'(i + 1);
            #2;
            exp0 = (((i / 2) % 2) == 0);
            n_checks++;
            if ({r0_rd_valid, r1_rd_valid} !== {exp0, !exp0} || rd_data !== 128'(i + 1)) begin
                n_errors++;
                $display("FAIL rr_beat%0d: got v0/v1=%b data=%h expected %b data=%h", i,
                         {r0_rd_valid, r1_rd_valid}, rd_data, {exp0, !exp0}, 128'(i + 1));
            end
        end
        step();
        rdf_valid = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_idle: got busy=%b expected 0", busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            r0_req  = 1'b1;
            r0_addr = 31'h0000200;
            #2;
            n_checks++;
            if (r0_gnt !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_gnt%0d: got %b expected 1", i, r0_gnt);
            end
        end
        step();
        #2;
        n_checks++;
        if ({r0_gnt, af_wr_en, busy} !== 3'b001 || af_addr_din !== 31'd0) begin
            n_errors++;
            $display("FAIL stall_fifth: got g0/wr/busy=%b addr=%h expected 001 addr=0",
                     {r0_gnt, af_wr_en, busy}, af_addr_din);
        end
        // First response: grant still blocked until its final beat retires.
        for (int i = 0; i < 2; i++) begin
            step();
            rdf_valid = 1'b1;
            rdf_dout  = 128'h55;
            #2;
            n_checks++;
            if ({r0_gnt, r0_rd_valid} !== 2'b01) begin
                n_errors++;
                $display("FAIL stall_beat%0d: got g0/v0=%b expected 01", i, {r0_gnt, r0_rd_valid});
            end
        end
        step();
        rdf_valid = 1'b0;
        #2;
        n_checks++;
        if ({r0_gnt, af_wr_en} !== 2'b11 || af_addr_din !== 31'h0000200) begin
            n_errors++;
            $display("FAIL stall_release: got g0/wr=%b addr=%h expected 11 addr=0000200",
                     {r0_gnt, af_wr_en}, af_addr_din);
        end
        step();
        r0_req = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_af_full();
        do_reset();
        step();
        r0_req  = 1'b1;
        r0_addr = 31'h0000300;
        #2;
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            n_errors++;
            $display("FAIL aff_pre: got %b expected 10", {r0_gnt, r1_gnt});
        end
        // Both requesting while full: no grant, priority must stay with r1.
        for (int i = 0; i < 3; i++) begin
            step();
            af_full = 1'b1;
            r0_req  = 1'b1;
            r1_req  = 1'b1;
            r1_addr = 31'h7ABCDEF;
            #2;
            n_checks++;
            if ({r0_gnt, r1_gnt, af_wr_en} !== 3'b000 || af_addr_din !== 31'd0) begin
                n_errors++;
                $display("FAIL aff_block%0d: got g0/g1/wr=%b addr=%h expected 000 addr=0",
                         i, {r0_gnt, r1_gnt, af_wr_en}, af_addr_din);
            end
        end
        step();
        af_full = 1'b0;
        #2;
        n_checks++;
        if ({r0_gnt, r1_gnt, af_wr_en} !== 3'b011 || af_addr_din !== 31'h7ABCDEF) begin
            n_errors++;
            $display("FAIL aff_release: got g0/g1/wr=%b addr=%h expected 011 addr=7abcdef",
                     {r0_gnt, r1_gnt, af_wr_en}, af_addr_din);
        end
        step();
        r1_req = 1'b0;
        #2;
        n_checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10 || af_addr_din !== 31'h0000300) begin
            n_errors++;
            $display("FAIL aff_next: got %b addr=%h expected 10 addr=0000300",
                     {r0_gnt, r1_gnt}, af_addr_din);
        end
        step();
        r0_req = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_orphan();
        do_reset();
        step();
        r0_req = 1'b1;
        r0_addr = 31'h0000777;
        step();
        r0_req = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL orphan_pre_busy: got %b expected 1", busy);
        end
        // Reset with a request outstanding: its beats become orphans.
        do_reset();
        #2;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL orphan_reset_busy: got %b expected 0", busy);
        end
        step();
        rdf_valid = 1'b1;
        rdf_dout  = 128'hDEAD;
        #2;
        n_checks++;
        if ({rdf_rd_en, r0_rd_valid, r1_rd_valid, err_orphan} !== 4'b0000) begin
            n_errors++;
            $display("FAIL orphan_beat: got en/v0/v1/err=%b expected 0000",
                     {rdf_rd_en, r0_rd_valid, r1_rd_valid, err_orphan});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            rdf_valid = 1'b0;
            #2;
            n_checks++;
            if (err_orphan !== 1'b1) begin
                n_errors++;
                $display("FAIL orphan_sticky%0d: got %b expected 1", i, err_orphan);
            end
        end
        do_reset();
        #2;
        n_checks++;
        if (err_orphan !== 1'b0) begin
            n_errors++;
            $display("FAIL orphan_clear: got %b expected 0", err_orphan);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_same_cycle();
        do_reset();
        step();
        r0_req  = 1'b1;
        r0_addr = 31'h0000400;
        #2;
        n_checks++;
        if (r0_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL same_gnt0: got %b expected 1", r0_gnt);
        end
        step();
        r0_req    = 1'b0;
        rdf_valid = 1'b1;
        rdf_dout  = 128'hD1;
        #2;
        n_checks++;
        if ({r0_rd_valid, r1_rd_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL same_beat1: got %b expected 10", {r0_rd_valid, r1_rd_valid});
        end
        // New grant coincides with the final beat of the earlier request.
        step();
        r1_req   = 1'b1;
        r1_addr  = 31'h0000500;
        rdf_dout = 128'hD2;
        #2;
        n_checks++;
        if ({r1_gnt, r0_rd_valid, r1_rd_valid, rdf_rd_en} !== 4'b1101 || af_addr_din !== 31'h0000500) begin
            n_errors++;
            $display("FAIL same_overlap: got g1/v0/v1/en=%b addr=%h expected 1101 addr=0000500",
                     {r1_gnt, r0_rd_valid, r1_rd_valid, rdf_rd_en}, af_addr_din);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            r1_req   = 1'b0;
            rdf_dout = 128'hE0 + 128'(i);
            #2;
            n_checks++;
            if ({busy, r0_rd_valid, r1_rd_valid} !== 3'b101 || rd_data !== 128'hE0 + 128'(i)) begin
                n_errors++;
                $display("FAIL same_r1beat%0d: got busy/v0/v1=%b data=%h expected 101 data=%h",
                         i, {busy, r0_rd_valid, r1_rd_valid}, rd_data, 128'hE0 + 128'(i));
            end
        end
        step();
        rdf_valid = 1'b0;
        #2;
        n_checks++;
        if ({busy, err_orphan} !== 2'b00) begin
            n_errors++;
            $display("FAIL same_done: got busy/err=%b expected 00", {busy, err_orphan});
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_af_full();
        test_orphan();
        test_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
